// File: rtl/connect_pkg.sv
// connect_pkg: shared types and helpers for the Connect Four turn controller
// and the board block. Holds the turn state enum and the width helper so that
// player and column buses agree on both sides of the interface.
package connect_pkg;

    // Turn controller states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_DROP   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_CHANGE = 3'd4,
        ST_OVER   = 3'd5
    } turn_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : connect_pkg

// File: rtl/turn_wrap_counter.sv
// turn_wrap_counter: modulo-MAX up/down counter with a synchronous load.
// Counts 0..MAX-1 and wraps in both directions (MAX-1 -> 0 on inc,
// 0 -> MAX-1 on dec). inc and dec together cancel. load beats both.
// Used for the column cursor and for player rotation.
module turn_wrap_counter
    import connect_pkg::*;
#(
    parameter int MAX     = 2,
    parameter int WIDTH   = 1,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MAX - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_next;

    // Next count: load, then single-direction step with wrap, else hold.
    always_comb begin
        // NOTE: default first so every path assigns w_next and no latch is inferred.
        w_next = r_count;
        if (load) begin
            w_next = load_val;
        end else if (inc && !dec) begin
            w_next = (r_count == LAST) ? '0 : r_count + ONE;
        end else if (dec && !inc) begin
            w_next = (r_count == '0) ? LAST : r_count - ONE;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values, independent of block order.
        if (reset) begin
            r_count <= RESET;
        end else begin
            r_count <= w_next;
        end
    end

    assign count = r_count;

endmodule : turn_wrap_counter

// File: rtl/turn_fsm.sv
// turn_fsm: game-turn controller for the Connect Four datapath.
// Walks players through column selection, piece drop and win/draw check.
// All outputs are Moore outputs decoded from registered state.
// Optional feature: define TURN_TIMEOUT_EN to build a per-turn SELECT
// timeout that forfeits the turn after TIMEOUT_CYCLES idle cycles.
module turn_fsm
    import connect_pkg::*;
#(
    parameter int NUM_PLAYERS    = 2,
    parameter int NUM_COLS       = 7,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enter,
    input  logic                                left,
    input  logic                                right,
    input  logic                                drop_done,
    input  logic                                drop_ok,
    input  logic                                check_valid,
    input  logic                                win,
    input  logic                                draw,
    output logic [clog2_min1(NUM_PLAYERS)-1:0]  player,
    output logic [clog2_min1(NUM_COLS)-1:0]     column,
    output logic                                sel_column,
    output logic                                drop_req,
    output logic                                change,
    output logic                                game_over,
    output logic                                winner_valid,
    output logic                                timeout
);

    localparam int PW = clog2_min1(NUM_PLAYERS);
    localparam int CW = clog2_min1(NUM_COLS);
    localparam logic [CW-1:0] COL_HOME = CW'(NUM_COLS / 2);

    turn_state_t r_state;
    turn_state_t w_next_state;

    logic          r_win;        // outcome latched when the game ends
    logic          w_start;      // new game begins this cycle
    logic          w_move;       // a single-direction cursor move is accepted
    logic          w_finish;     // win-check reports a finished game
    logic          w_expired;    // SELECT timer ran out this cycle
    logic          w_timeout;
    logic [PW-1:0] w_player;
    logic [CW-1:0] w_column;

    assign w_start  = (r_state == ST_IDLE) && enter;
    assign w_move   = (r_state == ST_SELECT) && !enter && (left ^ right);
    assign w_finish = (r_state == ST_CHECK) && check_valid && (win || draw);

    // State register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (enter) w_next_state = ST_SELECT;
            end
            ST_SELECT: begin
                if (enter)          w_next_state = ST_DROP;
                else if (w_expired) w_next_state = ST_CHANGE;
            end
            ST_DROP: begin
                if (drop_done) w_next_state = drop_ok ? ST_CHECK : ST_SELECT;
            end
            ST_CHECK: begin
                if (check_valid) w_next_state = (win || draw) ? ST_OVER : ST_CHANGE;
            end
            ST_CHANGE: begin
                w_next_state = ST_SELECT;
            end
            ST_OVER: begin
                if (enter) w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outcome flag: win beats draw; held unchanged while in OVER.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_win <= 1'b0;
        end else if (w_finish) begin
            r_win <= win;
        end
    end

    // Column cursor: re-centred at game start, moved only in SELECT.
    turn_wrap_counter #(
        .MAX     (NUM_COLS),
        .WIDTH   (CW),
        .RST_VAL (NUM_COLS / 2)
    ) u_column (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_move && right),
        .dec      (w_move && left),
        .load     (w_start),
        .load_val (COL_HOME),
        .count    (w_column)
    );

    // Player rotation: cleared at game start, advanced on leaving CHANGE.
    turn_wrap_counter #(
        .MAX     (NUM_PLAYERS),
        .WIDTH   (PW),
        .RST_VAL (0)
    ) u_player (
        .clk      (clk),
        .reset    (reset),
        .inc      (r_state == ST_CHANGE),
        .dec      (1'b0),
        .load     (w_start),
        .load_val ('0),
        .count    (w_player)
    );

`ifdef TURN_TIMEOUT_EN
    localparam int TW = clog2_min1(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout;
    logic          w_enter_select;

    assign w_enter_select = (w_next_state == ST_SELECT) && (r_state != ST_SELECT);
    assign w_expired      = (r_state == ST_SELECT) && (r_tmo_cnt == '0);

    // SELECT timer: reloads on entry and on each cursor move, counts down to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= TMO_LOAD;
        end else if (w_enter_select || w_move) begin
            r_tmo_cnt <= TMO_LOAD;
        end else if ((r_state == ST_SELECT) && (r_tmo_cnt != '0)) begin
            r_tmo_cnt <= r_tmo_cnt - TMO_ONE;
        end
    end

    // Forfeit pulse: registered alongside the move into CHANGE; enter wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_expired && !enter;
        end
    end

    assign w_timeout = r_timeout;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
    assign w_expired      = 1'b0;
    assign w_timeout      = 1'b0;
`endif

    // Moore output decode from registered state and counters.
    always_comb begin
        sel_column   = (r_state == ST_SELECT);
        drop_req     = (r_state == ST_DROP);
        change       = (r_state == ST_CHANGE);
        game_over    = (r_state == ST_OVER);
        winner_valid = (r_state == ST_OVER) && r_win;
        timeout      = w_timeout;
        player       = w_player;
        column       = w_column;
    end

endmodule : turn_fsm

// File: tb/tb_turn_fsm.sv
// tb_turn_fsm: self-checking bench for turn_fsm (3 players, 7 columns,
// timeout of 8 cycles when TURN_TIMEOUT_EN is defined). The reference model
// tracks only the cursor position and the player index with modular arithmetic.
module tb_turn_fsm;

    localparam int NP = 3;
    localparam int NC = 7;
    localparam int TC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enter = 1'b0, left = 1'b0, right = 1'b0;
    logic       drop_done = 1'b0, drop_ok = 1'b0;
    logic       check_valid = 1'b0, win = 1'b0, draw = 1'b0;
    logic [1:0] player;
    logic [2:0] column;
    logic       sel_column, drop_req, change, game_over, winner_valid, timeout;

    int checks = 0;
    int errors = 0;
    int m_player = 0;
    int m_col = NC / 2;

    turn_fsm #(
        .NUM_PLAYERS    (NP),
        .NUM_COLS       (NC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enter        (enter),
        .left         (left),
        .right        (right),
        .drop_done    (drop_done),
        .drop_ok      (drop_ok),
        .check_valid  (check_valid),
        .win          (win),
        .draw         (draw),
        .player       (player),
        .column       (column),
        .sel_column   (sel_column),
        .drop_req     (drop_req),
        .change       (change),
        .game_over    (game_over),
        .winner_valid (winner_valid),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        enter = 0; left = 0; right = 0; drop_done = 0; drop_ok = 0;
        check_valid = 0; win = 0; draw = 0;
    endtask

    task automatic pulse_enter();
        enter = 1; tick(); enter = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        reset = 1; tick(); tick(); reset = 0;
        checks++;
        if ({sel_column, drop_req, change, game_over, winner_valid, timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {sel_column, drop_req, change, game_over, winner_valid, timeout});
        end
        checks++;
        if (player !== 2'd0) begin
            errors++; $display("FAIL reset_player: got %0d expected 0", player);
        end
        checks++;
        if (column !== 3'd3) begin
            errors++; $display("FAIL reset_column: got %0d expected 3", column);
        end
        m_player = 0; m_col = NC / 2;
    endtask

    // ------------------------------------------------------------------
    task automatic test_cursor();
        int dirs[6] = '{1, 1, 1, 1, -1, 0};
        pulse_enter();
        checks++;
        if (sel_column !== 1'b1 || column !== 3'd3 || player !== 2'd0) begin
            errors++;
            $display("FAIL enter_select: sel=%b col=%0d plr=%0d expected sel=1 col=3 plr=0",
                     sel_column, column, player);
        end
        // Directed wrap sequence then random moves; 0 means left and right together.
        for (int i = 0; i < 26; i++) begin
            int d;
            d = (i < 6) ? dirs[i] : int'($urandom_range(0, 2)) - 1;
            right = (d >= 0); left = (d <= 0);
            tick(); clear_inputs();
            m_col = (m_col + d + NC) % NC;
            checks++;
            if (column !== 3'(m_col) || sel_column !== 1'b1) begin
                errors++;
                $display("FAIL cursor_move[%0d]: col=%0d sel=%b expected col=%0d sel=1",
                         i, column, sel_column, m_col);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_drop_retry();
        drop_done = 1; drop_ok = 1; tick(); clear_inputs();
        checks++;
        if (sel_column !== 1'b1 || drop_req !== 1'b0) begin
            errors++;
            $display("FAIL ignore_drop_in_select: sel=%b drop=%b expected sel=1 drop=0", sel_column, drop_req);
        end
        enter = 1; right = 1; tick(); clear_inputs();
        checks++;
        if (drop_req !== 1'b1 || column !== 3'(m_col)) begin
            errors++;
            $display("FAIL enter_priority: drop=%b col=%0d expected drop=1 col=%0d", drop_req, column, m_col);
        end
        tick(); tick();
        checks++;
        if (drop_req !== 1'b1) begin
            errors++; $display("FAIL drop_req_held: got %b expected 1", drop_req);
        end
        drop_done = 1; drop_ok = 0; tick(); clear_inputs();
        checks++;
        if (sel_column !== 1'b1 || drop_req !== 1'b0 || player !== 2'(m_player) || column !== 3'(m_col)) begin
            errors++;
            $display("FAIL column_full_retry: sel=%b drop=%b plr=%0d col=%0d expected 1 0 %0d %0d",
                     sel_column, drop_req, player, column, m_player, m_col);
        end
        pulse_enter();
        drop_done = 1; drop_ok = 1; tick(); clear_inputs();
        tick();
        checks++;
        if ({sel_column, drop_req, change, game_over} !== 4'b0) begin
            errors++;
            $display("FAIL wait_check: flags=%b expected 0000", {sel_column, drop_req, change, game_over});
        end
        check_valid = 1; tick(); clear_inputs();
        checks++;
        if (change !== 1'b1 || sel_column !== 1'b0) begin
            errors++; $display("FAIL change_pulse: chg=%b sel=%b expected 1 0", change, sel_column);
        end
        tick();
        m_player = (m_player + 1) % NP;
        checks++;
        if (change !== 1'b0 || sel_column !== 1'b1 || player !== 2'(m_player) || column !== 3'(m_col)) begin
            errors++;
            $display("FAIL next_player: chg=%b sel=%b plr=%0d col=%0d expected 0 1 %0d %0d",
                     change, sel_column, player, column, m_player, m_col);
        end
    endtask

    // ------------------------------------------------------------------
    // Three minimum-length turns, board answering in the request cycle.
    task automatic test_rotation();
        for (int t = 0; t < 3; t++) begin
            enter = 1; tick(); clear_inputs();
            drop_done = 1; drop_ok = 1;
            checks++;
            if (drop_req !== 1'b1) begin
                errors++; $display("FAIL rot_drop[%0d]: got %b expected 1", t, drop_req);
            end
            tick(); clear_inputs();
            check_valid = 1; tick(); clear_inputs();
            checks++;
            if (change !== 1'b1) begin
                errors++; $display("FAIL rot_change[%0d]: got %b expected 1", t, change);
            end
            tick();
            m_player = (m_player + 1) % NP;
            checks++;
            if (sel_column !== 1'b1 || player !== 2'(m_player)) begin
                errors++;
                $display("FAIL rot_player[%0d]: sel=%b plr=%0d expected sel=1 plr=%0d",
                         t, sel_column, player, m_player);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_over();
        pulse_enter();
        drop_done = 1; drop_ok = 1; tick(); clear_inputs();
        check_valid = 1; win = 1; draw = 1; tick(); clear_inputs();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (game_over !== 1'b1 || winner_valid !== 1'b1 || player !== 2'(m_player) || column !== 3'(m_col)) begin
                errors++;
                $display("FAIL over_win_hold[%0d]: over=%b wv=%b plr=%0d col=%0d expected 1 1 %0d %0d",
                         i, game_over, winner_valid, player, column, m_player, m_col);
            end
            {left, right, drop_done, drop_ok, check_valid, win, draw} = 7'($urandom());
            tick(); clear_inputs();
        end
        pulse_enter();
        checks++;
        if ({sel_column, drop_req, change, game_over, winner_valid} !== 5'b0) begin
            errors++;
            $display("FAIL over_to_idle: flags=%b expected 00000",
                     {sel_column, drop_req, change, game_over, winner_valid});
        end
        pulse_enter();
        m_player = 0; m_col = NC / 2;
        checks++;
        if (sel_column !== 1'b1 || player !== 2'd0 || column !== 3'd3) begin
            errors++;
            $display("FAIL restart: sel=%b plr=%0d col=%0d expected 1 0 3", sel_column, player, column);
        end
        pulse_enter();
        drop_done = 1; drop_ok = 1; tick(); clear_inputs();
        check_valid = 1; draw = 1; tick(); clear_inputs();
        checks++;
        if (game_over !== 1'b1 || winner_valid !== 1'b0 || player !== 2'(m_player)) begin
            errors++;
            $display("FAIL over_draw: over=%b wv=%b plr=%0d expected 1 0 %0d",
                     game_over, winner_valid, player, m_player);
        end
        pulse_enter();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_in_drop();
        pulse_enter();
        right = 1; tick(); clear_inputs();
        pulse_enter();
        checks++;
        if (drop_req !== 1'b1) begin
            errors++; $display("FAIL rst_pre_drop: got %b expected 1", drop_req);
        end
        reset = 1; enter = 1; drop_done = 1; drop_ok = 1; tick(); clear_inputs();
        checks++;
        if (drop_req !== 1'b0 || sel_column !== 1'b0 || player !== 2'd0 || column !== 3'd3) begin
            errors++;
            $display("FAIL rst_in_drop: drop=%b sel=%b plr=%0d col=%0d expected 0 0 0 3",
                     drop_req, sel_column, player, column);
        end
        reset = 0; tick();
        checks++;
        if ({sel_column, drop_req, change, game_over} !== 4'b0) begin
            errors++; $display("FAIL rst_stays_idle: flags=%b expected 0000", {sel_column, drop_req, change, game_over});
        end
        m_player = 0; m_col = NC / 2;
    endtask

`ifdef TURN_TIMEOUT_EN
    // ------------------------------------------------------------------
    task automatic test_timeout();
        int n;
        pulse_enter();
        n = 0;
        while (timeout !== 1'b1 && n < 30) begin tick(); n++; end
        checks++;
        if (n != TC || change !== 1'b1) begin
            errors++; $display("FAIL timeout_idle: cycles=%0d chg=%b expected %0d 1", n, change, TC);
        end
        tick();
        m_player = (m_player + 1) % NP;
        checks++;
        if (timeout !== 1'b0 || sel_column !== 1'b1 || player !== 2'(m_player)) begin
            errors++;
            $display("FAIL timeout_forfeit: tmo=%b sel=%b plr=%0d expected 0 1 %0d",
                     timeout, sel_column, player, m_player);
        end
        // A cursor move restarts the full allowance.
        for (int i = 0; i < 5; i++) tick();
        right = 1; tick(); clear_inputs();
        m_col = (m_col + 1) % NC;
        n = 0;
        while (timeout !== 1'b1 && n < 30) begin tick(); n++; end
        checks++;
        if (n != TC) begin
            errors++; $display("FAIL timeout_reload: cycles=%0d expected %0d", n, TC);
        end
        tick();
        m_player = (m_player + 1) % NP;
        // Enter on the expiry cycle beats the timeout.
        for (int i = 0; i < TC - 1; i++) tick();
        checks++;
        if (sel_column !== 1'b1 || timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_early: sel=%b tmo=%b expected 1 0", sel_column, timeout);
        end
        enter = 1; tick(); clear_inputs();
        checks++;
        if (drop_req !== 1'b1 || timeout !== 1'b0 || change !== 1'b0) begin
            errors++;
            $display("FAIL timeout_enter_wins: drop=%b tmo=%b chg=%b expected 1 0 0", drop_req, timeout, change);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL timeout_late: got %b expected 0", timeout);
        end
        drop_done = 1; drop_ok = 1; tick(); clear_inputs();
        check_valid = 1; tick(); clear_inputs();
        tick();
        m_player = (m_player + 1) % NP;
        checks++;
        if (sel_column !== 1'b1 || player !== 2'(m_player) || column !== 3'(m_col)) begin
            errors++;
            $display("FAIL timeout_after_turn: sel=%b plr=%0d col=%0d expected 1 %0d %0d",
                     sel_column, player, column, m_player, m_col);
        end
    endtask
`else
    // ------------------------------------------------------------------
    task automatic test_no_timeout();
        bit seen;
        seen = 0;
        pulse_enter();
        for (int i = 0; i < 3 * TC; i++) begin
            tick();
            if (timeout !== 1'b0 || sel_column !== 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL no_timeout: left SELECT or pulsed timeout while idle");
        end
    endtask
`endif

    // ------------------------------------------------------------------
    // Random games against the position/player model.
    task automatic test_random();
        reset = 1; tick(); reset = 0;
        pulse_enter();
        m_player = 0; m_col = NC / 2;
        for (int t = 0; t < 40; t++) begin
            int nmoves, nfail, outcome;
            nmoves = $urandom_range(0, 4);
            for (int i = 0; i < nmoves; i++) begin
                int d;
                d = int'($urandom_range(0, 2)) - 1;
                right = (d >= 0); left = (d <= 0);
                tick(); clear_inputs();
                m_col = (m_col + d + NC) % NC;
                checks++;
                if (column !== 3'(m_col)) begin
                    errors++; $display("FAIL rnd_cursor[%0d]: got %0d expected %0d", t, column, m_col);
                end
            end
            pulse_enter();
            nfail = $urandom_range(0, 2);
            for (int f = 0; f <= nfail; f++) begin
                for (int g = int'($urandom_range(0, 3)); g > 0; g--) begin
                    {check_valid, win, draw} = 3'($urandom());
                    tick(); clear_inputs();
                end
                checks++;
                if (drop_req !== 1'b1) begin
                    errors++; $display("FAIL rnd_drop_req[%0d]: got %b expected 1", t, drop_req);
                end
                drop_done = 1; drop_ok = (f == nfail); tick(); clear_inputs();
                if (f != nfail) begin
                    checks++;
                    if (sel_column !== 1'b1 || column !== 3'(m_col) || player !== 2'(m_player)) begin
                        errors++;
                        $display("FAIL rnd_retry[%0d]: sel=%b col=%0d plr=%0d expected 1 %0d %0d",
                                 t, sel_column, column, player, m_col, m_player);
                    end
                    pulse_enter();
                end
            end
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                {win, draw, drop_done, left, right} = 5'($urandom());
                tick(); clear_inputs();
            end
            outcome = $urandom_range(0, 9);
            check_valid = 1; win = (outcome == 0 || outcome == 2); draw = (outcome == 1 || outcome == 2);
            tick(); clear_inputs();
            if (outcome > 2) begin
                checks++;
                if (change !== 1'b1) begin
                    errors++; $display("FAIL rnd_change[%0d]: got %b expected 1", t, change);
                end
                tick();
                m_player = (m_player + 1) % NP;
                checks++;
                if (sel_column !== 1'b1 || player !== 2'(m_player) || column !== 3'(m_col)) begin
                    errors++;
                    $display("FAIL rnd_next[%0d]: sel=%b plr=%0d col=%0d expected 1 %0d %0d",
                             t, sel_column, player, column, m_player, m_col);
                end
            end else begin
                checks++;
                if (game_over !== 1'b1 || winner_valid !== (outcome != 1) || player !== 2'(m_player)) begin
                    errors++;
                    $display("FAIL rnd_over[%0d]: over=%b wv=%b plr=%0d expected 1 %0d %0d",
                             t, game_over, winner_valid, player, (outcome != 1), m_player);
                end
                pulse_enter();
                pulse_enter();
                m_player = 0; m_col = NC / 2;
                checks++;
                if (sel_column !== 1'b1 || player !== 2'd0 || column !== 3'd3) begin
                    errors++;
                    $display("FAIL rnd_restart[%0d]: sel=%b plr=%0d col=%0d expected 1 0 3",
                             t, sel_column, player, column);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_cursor();
        test_drop_retry();
        test_rotation();
        test_over();
        test_reset_in_drop();
`ifdef TURN_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_turn_fsm
